// File: rtl/ball_vertical_bounce_if.sv
// Bundles the signals between the VGA timing generator, the vertical ball generator and the vertical bounce block.
// BALL_BOUNCE_COUNT_EN adds the 8-bit bounce counter output.
interface ball_vertical_bounce_if;
  logic       i_HReset;
  logic       i_VBlank;
  logic       i_Ball_Video;
  logic       o_VDir;
  logic       o_Bounce;
`ifdef BALL_BOUNCE_COUNT_EN
  logic [7:0] o_Bounce_Count;

  modport master (
    output i_HReset, i_VBlank, i_Ball_Video,
    input  o_VDir, o_Bounce, o_Bounce_Count
  );
  modport slave (
    input  i_HReset, i_VBlank, i_Ball_Video,
    output o_VDir, o_Bounce, o_Bounce_Count
  );
`else
  modport master (
    output i_HReset, i_VBlank, i_Ball_Video,
    input  o_VDir, o_Bounce
  );
  modport slave (
    input  i_HReset, i_VBlank, i_Ball_Video,
    output o_VDir, o_Bounce
  );
`endif
endinterface

// File: rtl/ball_vertical_bounce.sv
// Vertical ball direction: latches top/bottom edge contact during the visible frame, commits a reversal at VBLANK start.
// Define BALL_BOUNCE_COUNT_EN to add a wrapping 8-bit count of committed bounces.
module ball_vertical_bounce #(
  parameter int unsigned p_LINES     = 480,
  parameter bit          p_INIT_VDIR = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  ball_vertical_bounce_if.slave bus
);

  localparam logic [9:0] LAST_LINE = 10'(p_LINES - 1);

  typedef enum logic [1:0] {
    S_WAIT_FRAME,
    S_ACTIVE,
    S_DECIDE,
    S_BLANK
  } state_t;

  state_t     state_q, state_d;
  logic       vblank_q;
  logic [9:0] line_q, line_d;
  logic       top_hit_q, top_hit_d;
  logic       bot_hit_q, bot_hit_d;
  logic       vdir_q, vdir_d;
  logic       bounce_q, bounce_d;
  logic       vb_rise, vb_fall;

  assign vb_rise = bus.i_VBlank & ~vblank_q;
  assign vb_fall = ~bus.i_VBlank & vblank_q;

  // Saturates on the last visible line so extra HResets can never alias back to line 0.
  always_comb begin
    line_d = line_q;
    if (bus.i_VBlank) begin
      line_d = '0;
    end else if (bus.i_HReset && (line_q != LAST_LINE)) begin
      line_d = line_q + 10'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    top_hit_d = top_hit_q;
    bot_hit_d = bot_hit_q;
    vdir_d    = vdir_q;
    bounce_d  = 1'b0;
    case (state_q)
      S_WAIT_FRAME: begin
        if (vb_fall) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (bus.i_Ball_Video && (line_q == '0))        top_hit_d = 1'b1;
        if (bus.i_Ball_Video && (line_q == LAST_LINE)) bot_hit_d = 1'b1;
        if (vb_rise) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        // Only the edge in the direction of travel can reverse the ball.
        if (vdir_q && bot_hit_q) begin
          vdir_d   = 1'b0;
          bounce_d = 1'b1;
        end else if (!vdir_q && top_hit_q) begin
          vdir_d   = 1'b1;
          bounce_d = 1'b1;
        end
        state_d = S_BLANK;
      end
      S_BLANK: begin
        top_hit_d = 1'b0;
        bot_hit_d = 1'b0;
        if (vb_fall) state_d = S_ACTIVE;
      end
      default: state_d = S_WAIT_FRAME;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= S_WAIT_FRAME;
      vblank_q  <= 1'b1;
      line_q    <= '0;
      top_hit_q <= 1'b0;
      bot_hit_q <= 1'b0;
      vdir_q    <= p_INIT_VDIR;
      bounce_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      vblank_q  <= bus.i_VBlank;
      line_q    <= line_d;
      top_hit_q <= top_hit_d;
      bot_hit_q <= bot_hit_d;
      vdir_q    <= vdir_d;
      bounce_q  <= bounce_d;
    end
  end

  assign bus.o_VDir   = vdir_q;
  assign bus.o_Bounce = bounce_q;

`ifdef BALL_BOUNCE_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + 8'(bounce_d);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_Bounce_Count = cnt_q;
`endif

endmodule

// File: tb/tb_ball_vertical_bounce.sv
// Directed and randomized frames against a frame-level model of edge hits and direction reversals.
module tb_ball_vertical_bounce;

  localparam int LINES = 480;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ball_vertical_bounce_if bus ();

  ball_vertical_bounce #(
    .p_LINES    (LINES),
    .p_INIT_VDIR(1'b1)
  ) dut (
    .i_Clk  (clk),
    .i_Reset(rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  bit   chk_en      = 1'b0;
  logic exp_vdir    = 1'b1;
  logic exp_bounce  = 1'b0;
`ifdef BALL_BOUNCE_COUNT_EN
  logic [7:0] exp_cnt = 8'd0;
`endif

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sample the outputs of the current cycle, then drive the inputs for it.
  task automatic step(input bit vb, input bit hr, input bit bv, input bit rs);
    @(negedge clk);
    if (chk_en) begin
      check("vdir", {7'd0, bus.o_VDir}, {7'd0, exp_vdir});
      check("bounce", {7'd0, bus.o_Bounce}, {7'd0, exp_bounce});
`ifdef BALL_BOUNCE_COUNT_EN
      check("count", bus.o_Bounce_Count, exp_cnt);
`endif
    end
    bus.i_VBlank     = vb;
    bus.i_HReset     = hr;
    bus.i_Ball_Video = bv;
    rst              = rs;
  endtask

  // Blank index 0 is the first VBlank-high cycle; the outcome shows from index 2 on.
  task automatic blank(input bit flip);
    logic ndir;
    ndir = flip ? ~exp_vdir : exp_vdir;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        exp_vdir   = ndir;
        exp_bounce = flip;
`ifdef BALL_BOUNCE_COUNT_EN
        if (flip) exp_cnt = exp_cnt + 8'd1;
`endif
      end
      if (k == 3) exp_bounce = 1'b0;
      step(1'b1, k[0], k >= 1, 1'b0);
    end
  endtask

  // One evaluated frame: hresets counted with saturation, hit = video on line 0 / last line.
  task automatic frame(input int n_hres, input bit v_top, input bit v_bot, input int mid);
    int line;
    bit top, bot, v;
    top = 1'b0;
    bot = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    line = 0;
    if (v_top) top = 1'b1;
    step(1'b0, 1'b0, v_top, 1'b0);
    for (int i = 0; i < n_hres; i++) begin
      v = (i == mid);
      if (v && line == 0) top = 1'b1;
      if (v && line == LINES - 1) bot = 1'b1;
      step(1'b0, 1'b1, v, 1'b0);
      line = (line + 1 > LINES - 1) ? LINES - 1 : line + 1;
    end
    if (v_bot && line == LINES - 1) bot = 1'b1;
    if (v_bot && line == 0) top = 1'b1;
    step(1'b0, 1'b0, v_bot, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    blank(exp_vdir ? bot : top);
  endtask

  initial begin
    bus.i_VBlank     = 1'b1;
    bus.i_HReset     = 1'b0;
    bus.i_Ball_Video = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);

    frame(LINES + 20, 1'b0, 1'b0, -1);   // no video
    frame(10, 1'b1, 1'b0, -1);           // top hit while moving down
    frame(LINES - 1, 1'b0, 1'b1, -1);    // bottom hit -> up
    frame(LINES + 50, 1'b0, 1'b1, -1);   // bottom hit while moving up, saturated counter
    frame(5, 1'b1, 1'b0, -1);            // top hit -> down
    frame(LINES - 1, 1'b1, 1'b1, -1);    // both edges -> single reversal to up
    frame(LINES - 1, 1'b0, 1'b0, -1);    // stays up
    frame(LINES - 1, 1'b0, 1'b0, 200);   // interior only

    for (int f = 0; f < 12; f++) begin
      frame($urandom_range(0, LINES + 40), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, LINES + 40));
    end

    // Reset mid-frame after hits on both edges: hits discarded, direction back to init.
    frame(LINES - 1, 1'b0, 1'b1, -1);
    if (exp_vdir) frame(LINES - 1, 1'b0, 1'b1, -1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < LINES - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    exp_vdir = 1'b1;
`ifdef BALL_BOUNCE_COUNT_EN
    exp_cnt = 8'd0;
`endif
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    blank(1'b0);

    // Reset coincident with VBlank rise after a bottom hit: no bounce.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < LINES - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    frame(LINES - 1, 1'b0, 1'b1, -1);    // next full frame bounces normally

`ifdef BALL_BOUNCE_COUNT_EN
    step(1'b1, 1'b0, 1'b0, 1'b1);
    exp_vdir = 1'b1;
    exp_cnt  = 8'd0;
    for (int f = 0; f < 257; f++) begin
      if (exp_vdir) frame(LINES - 1, 1'b0, 1'b1, -1);
      else          frame(2, 1'b1, 1'b0, -1);
    end
    @(negedge clk);
    check("count_wrap", bus.o_Bounce_Count, 8'd1);
`endif

    step(1'b1, 1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
